// File: rtl/dmi_req_bridge.sv
// DMI request bridge: turns DTM command pulses into a valid/ready request toward the debug
// module, tracks the response, and reports RISC-V-debug-style sticky op status to the DTM.
module dmi_req_bridge #(
  parameter int unsigned AWIDTH         = 7,
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned CNT_W          = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dmi_reg_en,
  input  logic              dmi_reg_wr_en,
  input  logic [AWIDTH-1:0] dmi_reg_addr,
  input  logic [31:0]       dmi_reg_wdata,
  input  logic              dmi_hard_reset,
  output logic [31:0]       dmi_reg_rdata,
  output logic [1:0]        rd_status,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_write,
  output logic [AWIDTH-1:0] req_addr,
  output logic [31:0]       req_wdata,
  input  logic              resp_valid,
  input  logic [31:0]       resp_rdata,
  input  logic              resp_err,
  output logic              req_abort
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            r_state;
  logic [1:0]        r_sticky;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_req_valid;
  logic              r_req_write;
  logic [AWIDTH-1:0] r_req_addr;
  logic [31:0]       r_req_wdata;
  logic [31:0]       r_dmi_rdata;
  logic [1:0]        r_rd_status;
  logic              r_req_abort;
  logic              r_hr_sync1;
  logic              r_hr_sync2;
  logic              r_hr_sync3;

  logic              w_hr_pulse;
  logic              w_expired;
  logic [1:0]        w_sticky_fail;
  logic [1:0]        w_rd_status_next;

  assign w_hr_pulse    = r_hr_sync2 & ~r_hr_sync3;
  assign w_expired     = (r_cnt == CntMax);
  // A failure must not downgrade an overrun already recorded for this op.
  assign w_sticky_fail = (r_sticky == 2'b11) ? 2'b11 : 2'b10;

  // Status seen by the DTM: sticky error first, then busy while an op is in flight.
  always_comb begin
    w_rd_status_next = 2'b00;
    if (r_sticky != 2'b00) begin
      w_rd_status_next = r_sticky;
    end else if (r_state != StIdle) begin
      w_rd_status_next = 2'b11;
    end
  end

  // Synchronise the TCK-domain hard reset and keep a delayed copy for rising-edge detect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hr_sync1 <= 1'b0;
      r_hr_sync2 <= 1'b0;
      r_hr_sync3 <= 1'b0;
    end else begin
      r_hr_sync1 <= dmi_hard_reset;
      r_hr_sync2 <= r_hr_sync1;
      r_hr_sync3 <= r_hr_sync2;
    end
  end

  // Request FSM with registered request, status, data and abort outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_sticky    <= 2'b00;
      r_cnt       <= '0;
      r_req_valid <= 1'b0;
      r_req_write <= 1'b0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_dmi_rdata <= '0;
      r_rd_status <= 2'b00;
      r_req_abort <= 1'b0;
    end else begin
      r_req_abort <= 1'b0;
      r_rd_status <= w_rd_status_next;
      if (w_hr_pulse) begin
        // Hard reset wins over everything, including a command on the same cycle.
        r_state     <= StIdle;
        r_sticky    <= 2'b00;
        r_req_valid <= 1'b0;
        r_cnt       <= '0;
        r_req_abort <= (r_state != StIdle);
      end else begin
        case (r_state)
          StIdle: begin
            r_cnt <= '0;
            if (dmi_reg_en && (r_sticky == 2'b00)) begin
              r_req_write <= dmi_reg_wr_en;
              r_req_addr  <= dmi_reg_addr;
              r_req_wdata <= dmi_reg_wdata;
              r_req_valid <= 1'b1;
              r_state     <= StReq;
            end
          end
          StReq: begin
            if (req_ready) begin
              r_req_valid <= 1'b0;
              r_cnt       <= '0;
              r_state     <= StWait;
            end else if (w_expired) begin
              r_sticky    <= w_sticky_fail;
              r_req_abort <= 1'b1;
              r_req_valid <= 1'b0;
              r_state     <= StIdle;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
            if (dmi_reg_en) begin
              r_sticky <= 2'b11;
            end
          end
          StWait: begin
            r_cnt <= r_cnt + CNT_W'(1);
            // A response on the expiry cycle counts as normal completion.
            if (resp_valid) begin
              if (resp_err) begin
                r_sticky <= w_sticky_fail;
              end else if (!r_req_write) begin
                r_dmi_rdata <= resp_rdata;
              end
              r_state <= StIdle;
            end else if (w_expired) begin
              r_sticky    <= w_sticky_fail;
              r_req_abort <= 1'b1;
              r_state     <= StIdle;
            end
            if (dmi_reg_en) begin
              r_sticky <= 2'b11;
            end
          end
          default: begin
            r_state     <= StIdle;
            r_req_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dmi_reg_rdata = r_dmi_rdata;
  assign rd_status     = r_rd_status;
  assign req_valid     = r_req_valid;
  assign req_write     = r_req_write;
  assign req_addr      = r_req_addr;
  assign req_wdata     = r_req_wdata;
  assign req_abort     = r_req_abort;

endmodule

// File: tb/tb_dmi_req_bridge.sv
// Self-checking bench for dmi_req_bridge: table of complete ops plus hand-written sequences
// for error, timeout, overrun, hard reset and mid-op reset; handshakes checked via scoreboard.
module tb_dmi_req_bridge;

  localparam int unsigned AW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dmi_reg_en = 1'b0;
  logic          dmi_reg_wr_en = 1'b0;
  logic [AW-1:0] dmi_reg_addr = '0;
  logic [31:0]   dmi_reg_wdata = '0;
  logic          dmi_hard_reset = 1'b0;
  logic [31:0]   dmi_reg_rdata;
  logic [1:0]    rd_status;
  logic          req_valid;
  logic          req_ready = 1'b0;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid = 1'b0;
  logic [31:0]   resp_rdata = '0;
  logic          resp_err = 1'b0;
  logic          req_abort;

  dmi_req_bridge #(
    .AWIDTH        (AW),
    .TIMEOUT_CYCLES(16),
    .CNT_W         (5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dmi_reg_en    (dmi_reg_en),
    .dmi_reg_wr_en (dmi_reg_wr_en),
    .dmi_reg_addr  (dmi_reg_addr),
    .dmi_reg_wdata (dmi_reg_wdata),
    .dmi_hard_reset(dmi_hard_reset),
    .dmi_reg_rdata (dmi_reg_rdata),
    .rd_status     (rd_status),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .req_abort     (req_abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } exp_t;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    int            ready_dly;
    int            resp_dly;
    logic [31:0]   rdata;
    logic          err;
    logic [31:0]   exp_rdata;
    logic [1:0]    exp_status;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[6];
  int   checks = 0;
  int   failures = 0;
  int   abort_cnt = 0;
  int   hs_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hard_reset_pulse();
    dmi_hard_reset = 1'b1;
    repeat (3) tick();
    dmi_hard_reset = 1'b0;
    repeat (3) tick();
  endtask

  // Issue one command, hand-shake it after ready_dly cycles, respond after resp_dly cycles.
  task automatic run_op(input vec_t v);
    exp_t e;
    e.wr = v.wr;
    e.addr = v.addr;
    e.wdata = v.wdata;
    sb_q.push_back(e);
    dmi_reg_en = 1'b1;
    dmi_reg_wr_en = v.wr;
    dmi_reg_addr = v.addr;
    dmi_reg_wdata = v.wdata;
    tick();
    dmi_reg_en = 1'b0;
    repeat (v.ready_dly) tick();
    chk("valid_before_hs", 32'(req_valid), 32'd1);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    chk("valid_after_hs", 32'(req_valid), 32'd0);
    chk("busy_status", 32'(rd_status), 32'd3);
    repeat (v.resp_dly) tick();
    resp_valid = 1'b1;
    resp_rdata = v.rdata;
    resp_err = v.err;
    tick();
    resp_valid = 1'b0;
    resp_err = 1'b0;
    tick();
    chk("op_rdata", dmi_reg_rdata, v.exp_rdata);
    chk("op_status", 32'(rd_status), 32'(v.exp_status));
  endtask

  // Handshake monitor: scoreboard pop, field stability while stalled, abort counting.
  initial begin
    logic          prev_valid;
    logic          prev_hs;
    logic          prev_wr;
    logic [AW-1:0] prev_addr;
    logic [31:0]   prev_wdata;
    exp_t          e;
    prev_valid = 1'b0;
    prev_hs = 1'b0;
    prev_wr = 1'b0;
    prev_addr = '0;
    prev_wdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        prev_hs = 1'b0;
      end else begin
        if (req_abort) abort_cnt++;
        if (req_valid && prev_valid && !prev_hs) begin
          chk("stable_write", 32'(req_write), 32'(prev_wr));
          chk("stable_addr", 32'(req_addr), 32'(prev_addr));
          chk("stable_wdata", req_wdata, prev_wdata);
        end
        if (req_valid && req_ready) begin
          hs_cnt++;
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_handshake addr=%h write=%b", req_addr, req_write);
          end else begin
            e = sb_q.pop_front();
            chk("hs_write", 32'(req_write), 32'(e.wr));
            chk("hs_addr", 32'(req_addr), 32'(e.addr));
            chk("hs_wdata", req_wdata, e.wdata);
          end
        end
        prev_valid = req_valid;
        prev_hs = req_valid && req_ready;
        prev_wr = req_write;
        prev_addr = req_addr;
        prev_wdata = req_wdata;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   seen;
    int   ab0;
    int   hs0;
    exp_t e;
    vec_t v;

    //           wr    addr    wdata         rdy res rdata          err   exp_rdata      st
    vecs[0] = '{1'b0, 7'h11, 32'h0000_0000, 0, 1, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 2'b00};
    vecs[1] = '{1'b1, 7'h10, 32'h8000_0001, 5, 2, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF, 2'b00};
    vecs[2] = '{1'b0, 7'h7F, 32'h0000_00AA, 2, 0, 32'hA5A5_5A5A, 1'b0, 32'hA5A5_5A5A, 2'b00};
    vecs[3] = '{1'b1, 7'h00, 32'hFFFF_FFFF, 0, 4, 32'h0000_0000, 1'b0, 32'hA5A5_5A5A, 2'b00};
    vecs[4] = '{1'b0, 7'h01, 32'h0000_0000, 1, 1, 32'h0000_0000, 1'b0, 32'h0000_0000, 2'b00};
    vecs[5] = '{1'b0, 7'h22, 32'h0000_0000, 0, 1, 32'hCAFE_F00D, 1'b1, 32'h0000_0000, 2'b10};

    // Reset state
    repeat (3) tick();
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_req_write", 32'(req_write), 32'd0);
    chk("rst_req_addr", 32'(req_addr), 32'd0);
    chk("rst_req_wdata", req_wdata, 32'd0);
    chk("rst_rdata", dmi_reg_rdata, 32'd0);
    chk("rst_status", 32'(rd_status), 32'd0);
    chk("rst_abort", 32'(req_abort), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i]);
      repeat (2) tick();
    end

    // Sticky error blocks new commands until a hard reset
    dmi_reg_en = 1'b1;
    dmi_reg_wr_en = 1'b0;
    dmi_reg_addr = 7'h05;
    tick();
    dmi_reg_en = 1'b0;
    tick();
    chk("err_blocks_valid", 32'(req_valid), 32'd0);
    chk("err_sticky", 32'(rd_status), 32'd2);
    ab0 = abort_cnt;
    hard_reset_pulse();
    chk("hr_clears_status", 32'(rd_status), 32'd0);
    chk("hr_idle_no_abort", 32'(abort_cnt - ab0), 32'd0);
    v = '{1'b0, 7'h06, 32'h0, 0, 0, 32'h1111_2222, 1'b0, 32'h1111_2222, 2'b00};
    run_op(v);

    // Timeout in WAIT: abort 16 cycles after handshake, late response ignored
    e = '{1'b0, 7'h30, 32'h0};
    sb_q.push_back(e);
    dmi_reg_en = 1'b1;
    dmi_reg_wr_en = 1'b0;
    dmi_reg_addr = 7'h30;
    dmi_reg_wdata = 32'h0;
    tick();
    dmi_reg_en = 1'b0;
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    seen = 0;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (req_abort) begin
        seen = i;
        break;
      end
    end
    chk("wait_timeout_cycles", 32'(seen), 32'd16);
    tick();
    chk("wait_abort_one_cycle", 32'(req_abort), 32'd0);
    chk("wait_timeout_status", 32'(rd_status), 32'd2);
    resp_valid = 1'b1;
    resp_rdata = 32'hBAD0_BAD0;
    tick();
    resp_valid = 1'b0;
    tick();
    chk("late_resp_rdata", dmi_reg_rdata, 32'h1111_2222);
    chk("late_resp_status", 32'(rd_status), 32'd2);
    hard_reset_pulse();

    // Timeout in REQ: never ready
    dmi_reg_en = 1'b1;
    dmi_reg_wr_en = 1'b1;
    dmi_reg_addr = 7'h31;
    tick();
    dmi_reg_en = 1'b0;
    seen = 0;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (req_abort) begin
        seen = i;
        break;
      end
    end
    chk("req_timeout_cycles", 32'(seen), 32'd16);
    chk("req_timeout_valid", 32'(req_valid), 32'd0);
    tick();
    chk("req_timeout_status", 32'(rd_status), 32'd2);
    hard_reset_pulse();

    // Overrun in WAIT: first op completes, status sticks at busy, single handshake
    hs0 = hs_cnt;
    e = '{1'b0, 7'h33, 32'h0};
    sb_q.push_back(e);
    dmi_reg_en = 1'b1;
    dmi_reg_wr_en = 1'b0;
    dmi_reg_addr = 7'h33;
    dmi_reg_wdata = 32'h0;
    tick();
    dmi_reg_en = 1'b0;
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    dmi_reg_en = 1'b1;
    dmi_reg_wr_en = 1'b1;
    dmi_reg_addr = 7'h44;
    dmi_reg_wdata = 32'h5555_AAAA;
    tick();
    dmi_reg_en = 1'b0;
    resp_valid = 1'b1;
    resp_rdata = 32'h600D_F00D;
    tick();
    resp_valid = 1'b0;
    tick();
    chk("overrun_rdata", dmi_reg_rdata, 32'h600D_F00D);
    chk("overrun_status", 32'(rd_status), 32'd3);
    repeat (3) tick();
    chk("overrun_one_hs", 32'(hs_cnt - hs0), 32'd1);
    chk("overrun_no_valid", 32'(req_valid), 32'd0);
    hard_reset_pulse();
    chk("overrun_cleared", 32'(rd_status), 32'd0);

    // Hard reset mid-REQ with ready low
    dmi_reg_en = 1'b1;
    dmi_reg_wr_en = 1'b1;
    dmi_reg_addr = 7'h12;
    dmi_reg_wdata = 32'h0BAD_CAFE;
    tick();
    dmi_reg_en = 1'b0;
    repeat (2) tick();
    ab0 = abort_cnt;
    dmi_hard_reset = 1'b1;
    repeat (4) tick();
    chk("hr_req_valid", 32'(req_valid), 32'd0);
    chk("hr_req_status", 32'(rd_status), 32'd0);
    chk("hr_req_abort_once", 32'(abort_cnt - ab0), 32'd1);
    dmi_hard_reset = 1'b0;
    repeat (3) tick();
    chk("hr_req_abort_total", 32'(abort_cnt - ab0), 32'd1);
    v = '{1'b0, 7'h13, 32'h0, 1, 1, 32'h7777_0001, 1'b0, 32'h7777_0001, 2'b00};
    run_op(v);

    // Synchronous reset mid-WAIT: everything back to reset values, no abort
    ab0 = abort_cnt;
    e = '{1'b1, 7'h55, 32'h9999_0000};
    sb_q.push_back(e);
    dmi_reg_en = 1'b1;
    dmi_reg_wr_en = 1'b1;
    dmi_reg_addr = 7'h55;
    dmi_reg_wdata = 32'h9999_0000;
    tick();
    dmi_reg_en = 1'b0;
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_valid", 32'(req_valid), 32'd0);
    chk("mid_rst_write", 32'(req_write), 32'd0);
    chk("mid_rst_addr", 32'(req_addr), 32'd0);
    chk("mid_rst_wdata", req_wdata, 32'd0);
    chk("mid_rst_rdata", dmi_reg_rdata, 32'd0);
    chk("mid_rst_status", 32'(rd_status), 32'd0);
    chk("mid_rst_abort", 32'(req_abort), 32'd0);
    repeat (2) tick();
    chk("mid_rst_idle_status", 32'(rd_status), 32'd0);
    chk("mid_rst_no_abort", 32'(abort_cnt - ab0), 32'd0);

    repeat (3) tick();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
